memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Downstream of the two caches. Consumes memory_request_0/1 and memory_request_ready_0/1, and returns memory_response_0/1 and memory_response_ready_0/1.
- Buffers one outstanding request per cache and arbitrates round-robin onto a single backing-RAM port.
- Routes each RAM reply back to the cache that issued the request.
- With the coherenter, closes the memory side of the two-cache system.

Parameters:
- ADDR_WIDTH, 16, address field width.
- DATA_WIDTH, 8, write-data field width.
- LINE_WIDTH, 16, read-response width.
- REQ_WIDTH, 1+ADDR_WIDTH+DATA_WIDTH (25), request word width.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before forced error completion.

Ports:
- clock  in  1  system clock. Single clock domain, rising edge.
- reset  in  1  synchronous, active-high reset.
- memory_request_0  in  REQ_WIDTH  cache 0 request. [24]=write(1)/read(0), [23:8]=address, [7:0]=write data.
- memory_request_ready_0  in  1  one-cycle pulse qualifying memory_request_0.
- memory_request_1  in  REQ_WIDTH  cache 1 request, same format.
- memory_request_ready_1  in  1  pulse qualifying memory_request_1.
- memory_response_0  out  LINE_WIDTH  read data to cache 0.
- memory_response_ready_0  out  1  one-cycle pulse qualifying memory_response_0.
- memory_response_1  out  LINE_WIDTH  read data to cache 1.
- memory_response_ready_1  out  1  one-cycle pulse qualifying memory_response_1.
- ram_request_valid  out  1  RAM command valid.
- ram_request_accept  in  1  RAM takes the command this cycle.
- ram_write  out  1  1=write, 0=read.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_write_data  out  DATA_WIDTH  RAM write byte.
- ram_response_valid  in  1  RAM completion, for both reads and writes.
- ram_read_data  in  LINE_WIDTH  RAM read line.
- overflow_error  out  2  sticky, per port: request arrived while that slot was occupied.
- timeout_error  out  1  sticky: a WAIT timed out.

Behaviour:
- Reset (synchronous):
  - All outputs go to 0.
  - Both slots are cleared. State goes to IDLE.
  - last_grant=1, so port 0 wins the first tie.
  - The timeout counter goes to 0.
  - Reset mid-transaction abandons the RAM transaction. A later ram_response_valid is ignored.
- Capture:
  - memory_request_ready_n high at an edge stores the request in slot n and sets pending_n.
  - If pending_n is already set and is not being released that same cycle, the request is dropped and overflow_error[n] is set.
  - If slot n is released in RESPOND in the same cycle a new pulse arrives, the new request is captured; no overflow.
- FSM, IDLE:
  - With no pending slot, stay in IDLE.
  - With one pending slot, grant it.
  - With both pending, grant the port that is not last_grant.
  - On a grant, update last_grant and go to ISSUE.
- FSM, ISSUE:
  - Drive ram_request_valid=1 with ram_write, ram_address and ram_write_data from the granted slot.
  - Hold these stable until ram_request_accept. The accept edge moves to WAIT.
- FSM, WAIT:
  - On ram_response_valid, latch the response data and go to RESPOND.
  - Response data is ram_read_data for a read and 16'h0000 for a write acknowledge.
  - The counter increments each WAIT cycle. If it reaches TIMEOUT_CYCLES, latch 16'hFFFF, set timeout_error and go to RESPOND.
  - ram_response_valid outside WAIT is ignored.
- FSM, RESPOND:
  - memory_response_ready_g=1 for exactly one cycle, with memory_response_g equal to the latched data.
  - Clear pending_g and go to IDLE.
  - The non-granted port's response outputs stay 0 (data also 0).
- Latency:
  - Request pulse at cycle 0, RAM accepting immediately and responding the cycle after accept: response pulse at cycle 4.
  - Cycle 1 IDLE grants, cycle 2 ISSUE, cycle 3 WAIT, cycle 4 RESPOND.
- Ordering:
  - Only one RAM transaction is in flight at a time. Per-port order is preserved.
  - A continuously pending port is served no later than every second grant (no starvation).

Decomposition:
- Shared package mem_pkg holds:
  - REQ_WRITE_BIT=24, REQ_ADDR_MSB=23, REQ_ADDR_LSB=8, REQ_DATA_MSB=7.
  - WRITE_ACK_DATA=16'h0000, TIMEOUT_DATA=16'hFFFF.
  - The state enum IDLE/ISSUE/WAIT/RESPOND.
- One sub-module: request_slot, the single-entry capture buffer with pending flag, release input and sticky overflow flag. It is instantiated twice.

Test Plan:
- Single read, port 0: req 25'h0_1234_00 pulse at cycle 0, RAM accepts immediately and returns 16'hBEEF the next cycle -> memory_response_ready_0 pulse at cycle 4 with 16'hBEEF; port 1 outputs stay 0.
- Simultaneous requests: both ports pulse in the same cycle (port 0 read 0x0010, port 1 read 0x0020) -> port 0 served first, then port 1; two RAM commands in that order; each response goes to the correct port.
- Fairness: port 1 re-requests each time it is answered while port 0 has one request pending -> grants alternate 1,0,1; port 0 is answered within 2 transactions.
- Write acknowledge and backpressure: port 1 write 0x00AA to 0x4000, ram_request_accept held low 3 cycles -> ram_request_valid, ram_write=1, ram_address=16'h4000, ram_write_data=8'hAA stable all 4 cycles; response pulse on port 1 with 16'h0000.
- Overflow and timeout:
  - Second port-0 pulse while its slot is pending -> overflow_error=2'b01 and the second request is never issued.
  - Separately, RAM never responds -> after 255 WAIT cycles, 16'hFFFF pulse and timeout_error=1.
- Reset during WAIT: assert reset, then RAM responds after deassert -> no response pulses, all outputs 0, and the next request completes normally.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// mem_pkg: request field positions, fixed response words and arbiter states
// shared by the memory arbiter and its request slots.
package mem_pkg;
    localparam int REQ_WRITE_BIT = 24;
    localparam int REQ_ADDR_MSB = 23;
    localparam int REQ_ADDR_LSB = 8;
    localparam int REQ_DATA_MSB = 7;
    localparam logic [15:0] WRITE_ACK_DATA = 16'h0000;
    localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_e;
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: cache request/response pulses, backing-RAM port and error flags.
// slave is the arbiter's view; master is the caches-plus-RAM side.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 16,
    parameter int REQ_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH
);
    logic [REQ_WIDTH-1:0] memory_request_0, memory_request_1;
    logic memory_request_ready_0, memory_request_ready_1;
    logic [LINE_WIDTH-1:0] memory_response_0, memory_response_1;
    logic memory_response_ready_0, memory_response_ready_1;
    logic ram_request_valid, ram_request_accept, ram_write;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic ram_response_valid;
    logic [LINE_WIDTH-1:0] ram_read_data;
    logic [1:0] overflow_error;
    logic timeout_error;
    modport slave (
        input memory_request_0, memory_request_1, memory_request_ready_0, memory_request_ready_1,
        input ram_request_accept, ram_response_valid, ram_read_data,
        output memory_response_0, memory_response_1, memory_response_ready_0, memory_response_ready_1,
        output ram_request_valid, ram_write, ram_address, ram_write_data, overflow_error, timeout_error
    );
    modport master (
        output memory_request_0, memory_request_1, memory_request_ready_0, memory_request_ready_1,
        output ram_request_accept, ram_response_valid, ram_read_data,
        input memory_response_0, memory_response_1, memory_response_ready_0, memory_response_ready_1,
        input ram_request_valid, ram_write, ram_address, ram_write_data, overflow_error, timeout_error
    );
endinterface

// File: rtl/memory_arbiter_request_slot.sv
// request_slot: single-entry request buffer with pending flag and sticky overflow.
// A capture in the same cycle as a release refills the slot without overflow.
module request_slot #(
    parameter int WIDTH = 25
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             capture,
    input  logic [WIDTH-1:0] req_in,
    input  logic             rel,
    output logic             pending,
    output logic [WIDTH-1:0] req,
    output logic             overflow
);
    logic pending_q, pending_d, overflow_q, overflow_d;
    logic [WIDTH-1:0] req_q, req_d;
    logic drop;

    always_comb begin
        drop = capture & pending_q & ~rel;
        pending_d = (capture & ~drop) | (pending_q & ~rel);
        req_d = (capture & ~drop) ? req_in : req_q;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= 1'b0;
            req_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            req_q <= req_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending = pending_q;
    assign req = req_q;
    assign overflow = overflow_q;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: buffers one request per cache, arbitrates round-robin onto one
// RAM port with a single transaction in flight, and routes each reply back.
module memory_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 16,
    parameter int REQ_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clock,
    input logic reset,
    memory_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e state_q, state_d;
    logic grant_q, grant_d, last_q, last_d, timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;
    logic [REQ_WIDTH-1:0] req0, req1, sel;
    logic [1:0] pend, rel, ovf;
    logic issue, respond;

    request_slot #(.WIDTH(REQ_WIDTH)) u_slot0 (
        .clock(clock), .reset(reset), .capture(bus.memory_request_ready_0), .req_in(bus.memory_request_0),
        .rel(rel[0]), .pending(pend[0]), .req(req0), .overflow(ovf[0])
    );

    request_slot #(.WIDTH(REQ_WIDTH)) u_slot1 (
        .clock(clock), .reset(reset), .capture(bus.memory_request_ready_1), .req_in(bus.memory_request_1),
        .rel(rel[1]), .pending(pend[1]), .req(req1), .overflow(ovf[1])
    );

    always_comb begin
        issue = state_q == ISSUE;
        respond = state_q == RESPOND;
        sel = grant_q ? req1 : req0;
        rel = respond ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        cnt_d = '0;
        data_d = data_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (|pend) begin
                // On a tie the port that did not win last time goes next.
                grant_d = (&pend) ? ~last_q : pend[1];
                last_d = grant_d;
                state_d = ISSUE;
            end
            ISSUE: state_d = bus.ram_request_accept ? WAIT : ISSUE;
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.ram_response_valid) begin
                    data_d = sel[REQ_WRITE_BIT] ? WRITE_ACK_DATA : bus.ram_read_data;
                    state_d = RESPOND;
                end else if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                    data_d = TIMEOUT_DATA;
                    timeout_d = 1'b1;
                    state_d = RESPOND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q <= 1'b1;
            cnt_q <= '0;
            data_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            data_q <= data_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.memory_response_ready_0 = rel[0];
    assign bus.memory_response_ready_1 = rel[1];
    assign bus.memory_response_0 = rel[0] ? data_q : '0;
    assign bus.memory_response_1 = rel[1] ? data_q : '0;
    assign bus.ram_request_valid = issue;
    assign bus.ram_write = issue & sel[REQ_WRITE_BIT];
    assign bus.ram_address = issue ? sel[REQ_ADDR_MSB:REQ_ADDR_LSB] : '0;
    assign bus.ram_write_data = issue ? sel[REQ_DATA_MSB:0] : '0;
    assign bus.overflow_error = ovf;
    assign bus.timeout_error = timeout_q;
endmodule
